// File: rtl/synth_cfg_tx.sv
// synth_cfg_tx
// CPU-clock-domain initiator of the 4-phase req/ack handshake into cpu_to_synth_cdc.
// The CPU writes shadow copies of the synth parameters. A commit snapshots the shadows
// into the frozen output registers and then raises cpu_req_o. The outputs stay frozen
// until the handshake has completed.
//
// Ports
//   clk_i, rst_i          CPU clock, synchronous active-high reset
//   wr_en_i/addr/data     IO-mem write port (0..N-1 voice FCW, 8 mod FCW, 9 mod shift,
//                         10 note enables, 11 commit, 12 status/err clear)
//   rd_addr_i/rd_data_o   combinational read port (12 = {err, pending, busy})
//   cpu_*_o               frozen transfer data; cpu_req_o is the registered request
//   cpu_ack_i             asynchronous acknowledge from the synth domain
//
// Configuration macro: SYNTH_CFG_TIMEOUT_EN adds a REQ timeout that sets a sticky err.
// Without it, REQ waits indefinitely and err reads as 0.
module synth_cfg_tx #(
  parameter int N_VOICES        = 4,
  parameter int ACK_SYNC_STAGES = 2,
  parameter int TIMEOUT_CYCLES  = 1024
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     wr_en_i,
  input  logic [3:0]               wr_addr_i,
  input  logic [31:0]              wr_data_i,
  input  logic [3:0]               rd_addr_i,
  output logic [31:0]              rd_data_o,
  output logic [N_VOICES*24-1:0]   cpu_carrier_fcws_o,
  output logic [23:0]              cpu_mod_fcw_o,
  output logic [4:0]               cpu_mod_shift_o,
  output logic [N_VOICES-1:0]      cpu_note_en_o,
  output logic                     cpu_req_o,
  input  logic                     cpu_ack_i
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_LOAD     = 2'd1,
    ST_REQ      = 2'd2,
    ST_WAIT_LOW = 2'd3
  } state_e;

  state_e                       state_q;
  logic [23:0]                  car_sh_q [N_VOICES];
  logic [23:0]                  car_sh_d [N_VOICES];
  logic [23:0]                  mod_fcw_sh_q, mod_fcw_sh_d;
  logic [4:0]                   mod_shift_sh_q, mod_shift_sh_d;
  logic [N_VOICES-1:0]          note_en_sh_q, note_en_sh_d;
  logic [23:0]                  car_out_q [N_VOICES];
  logic [23:0]                  mod_fcw_out_q;
  logic [4:0]                   mod_shift_out_q;
  logic [N_VOICES-1:0]          note_en_out_q;
  logic                         req_q;
  logic                         pending_q;
  logic [ACK_SYNC_STAGES-1:0]   ack_sync_q;
  logic                         ack_s;
  logic                         commit_s;
  logic                         busy_s;
  logic                         err_s;
  logic [23:0]                  car_pad_s [8];
  logic                         unused_s;

  assign ack_s    = ack_sync_q[ACK_SYNC_STAGES-1];
  assign commit_s = wr_en_i && (wr_addr_i == 4'd11);
  assign busy_s   = (state_q != ST_IDLE);
  assign unused_s = ^wr_data_i[31:24];

`ifdef SYNTH_CFG_TIMEOUT_EN
  logic [15:0] cnt_q;
  logic        err_q;
  logic        err_clr_s;
  assign err_clr_s = wr_en_i && (wr_addr_i == 4'd12) && wr_data_i[2];
  assign err_s     = err_q;
`else
  logic [15:0] unused_timeout_s;
  assign unused_timeout_s = 16'(TIMEOUT_CYCLES);
  assign err_s            = 1'b0;
`endif

  // Shadow next-state: a write replaces exactly one field.
  always_comb begin
    for (int i = 0; i < N_VOICES; i++) begin
      car_sh_d[i] = (wr_en_i && (wr_addr_i == 4'(i))) ? wr_data_i[23:0] : car_sh_q[i];
    end
    mod_fcw_sh_d   = (wr_en_i && (wr_addr_i == 4'd8))  ? wr_data_i[23:0]         : mod_fcw_sh_q;
    mod_shift_sh_d = (wr_en_i && (wr_addr_i == 4'd9))  ? wr_data_i[4:0]          : mod_shift_sh_q;
    note_en_sh_d   = (wr_en_i && (wr_addr_i == 4'd10)) ? wr_data_i[N_VOICES-1:0] : note_en_sh_q;
  end

  // Shadow registers and the cpu_ack synchronizer.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < N_VOICES; i++) car_sh_q[i] <= 24'd0;
      mod_fcw_sh_q   <= 24'd0;
      mod_shift_sh_q <= 5'd0;
      note_en_sh_q   <= '0;
      ack_sync_q     <= '0;
    end else begin
      car_sh_q       <= car_sh_d;
      mod_fcw_sh_q   <= mod_fcw_sh_d;
      mod_shift_sh_q <= mod_shift_sh_d;
      note_en_sh_q   <= note_en_sh_d;
      ack_sync_q     <= {ack_sync_q[ACK_SYNC_STAGES-2:0], cpu_ack_i};
    end
  end

  // Handshake FSM with the frozen outputs, pending flag and optional timeout.
  // The frozen outputs load on the edge that enters LOAD. They take the shadow
  // next-state, so the snapshot equals the shadows seen during the LOAD cycle.
  // Data is therefore stable for the whole LOAD cycle before cpu_req_o rises.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q         <= ST_IDLE;
      req_q           <= 1'b0;
      pending_q       <= 1'b0;
      for (int i = 0; i < N_VOICES; i++) car_out_q[i] <= 24'd0;
      mod_fcw_out_q   <= 24'd0;
      mod_shift_out_q <= 5'd0;
      note_en_out_q   <= '0;
`ifdef SYNTH_CFG_TIMEOUT_EN
      cnt_q           <= 16'd0;
      err_q           <= 1'b0;
`endif
    end else begin
`ifdef SYNTH_CFG_TIMEOUT_EN
      if (err_clr_s) err_q <= 1'b0;
`endif
      case (state_q)
        ST_IDLE: begin
          // A stale ack (after reset or abort) holds the commit as pending.
          // A commit coinciding with a pending start is absorbed.
          if ((commit_s || pending_q) && !ack_s) begin
            state_q         <= ST_LOAD;
            pending_q       <= 1'b0;
            car_out_q       <= car_sh_d;
            mod_fcw_out_q   <= mod_fcw_sh_d;
            mod_shift_out_q <= mod_shift_sh_d;
            note_en_out_q   <= note_en_sh_d;
          end else if (commit_s) begin
            pending_q <= 1'b1;
          end
        end
        ST_LOAD: begin
          state_q <= ST_REQ;
          req_q   <= 1'b1;
`ifdef SYNTH_CFG_TIMEOUT_EN
          cnt_q   <= 16'd0;
`endif
          if (commit_s) pending_q <= 1'b1;
        end
        ST_REQ: begin
          if (commit_s) pending_q <= 1'b1;
          if (ack_s) begin
            req_q   <= 1'b0;
            state_q <= ST_WAIT_LOW;
`ifdef SYNTH_CFG_TIMEOUT_EN
          end else if (cnt_q == 16'(TIMEOUT_CYCLES - 1)) begin
            req_q   <= 1'b0;
            err_q   <= 1'b1;
            state_q <= ST_WAIT_LOW;
          end else begin
            cnt_q <= cnt_q + 16'd1;
`endif
          end
        end
        ST_WAIT_LOW: begin
          if (commit_s) pending_q <= 1'b1;
          if (!ack_s) state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
          req_q   <= 1'b0;
        end
      endcase
    end
  end

  // Voice readback padded to the full 0..7 index range; absent voices read 0.
  always_comb begin
    for (int i = 0; i < 8; i++) car_pad_s[i] = 24'd0;
    for (int i = 0; i < N_VOICES; i++) car_pad_s[i] = car_sh_q[i];
  end

  // Combinational read mux.
  always_comb begin
    rd_data_o = 32'd0;
    case (rd_addr_i)
      4'd8:    rd_data_o = {8'd0, mod_fcw_sh_q};
      4'd9:    rd_data_o = {27'd0, mod_shift_sh_q};
      4'd10:   rd_data_o = {{(32-N_VOICES){1'b0}}, note_en_sh_q};
      4'd12:   rd_data_o = {29'd0, err_s, pending_q, busy_s};
      default: rd_data_o = rd_addr_i[3] ? 32'd0 : {8'd0, car_pad_s[rd_addr_i[2:0]]};
    endcase
  end

  for (genvar g = 0; g < N_VOICES; g++) begin : g_car_out
    assign cpu_carrier_fcws_o[24*g +: 24] = car_out_q[g];
  end
  assign cpu_mod_fcw_o   = mod_fcw_out_q;
  assign cpu_mod_shift_o = mod_shift_out_q;
  assign cpu_note_en_o   = note_en_out_q;
  assign cpu_req_o       = req_q;

endmodule

// File: tb/tb_synth_cfg_tx.sv
module tb_synth_cfg_tx;
  localparam int NV = 4;

  logic            clk_i = 1'b0;
  logic            rst_i;
  logic            wr_en_i;
  logic [3:0]      wr_addr_i;
  logic [31:0]     wr_data_i;
  logic [3:0]      rd_addr_i;
  logic [31:0]     rd_data_o;
  logic [NV*24-1:0] cpu_carrier_fcws_o;
  logic [23:0]     cpu_mod_fcw_o;
  logic [4:0]      cpu_mod_shift_o;
  logic [NV-1:0]   cpu_note_en_o;
  logic            cpu_req_o;
  logic            cpu_ack_i;

  int checks = 0;
  int errors = 0;

  // Behavioural model: the CPU-visible shadow registers and the snapshot
  // that the most recent accepted commit should have frozen.
  logic [23:0]     m_car [NV];
  logic [23:0]     m_mod;
  logic [4:0]      m_shift;
  logic [NV-1:0]   m_note;
  logic [NV*24-1:0] e_car;
  logic [23:0]     e_mod;
  logic [4:0]      e_shift;
  logic [NV-1:0]   e_note;

  synth_cfg_tx #(.N_VOICES(NV), .ACK_SYNC_STAGES(2), .TIMEOUT_CYCLES(16)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .wr_en_i(wr_en_i), .wr_addr_i(wr_addr_i),
    .wr_data_i(wr_data_i), .rd_addr_i(rd_addr_i), .rd_data_o(rd_data_o),
    .cpu_carrier_fcws_o(cpu_carrier_fcws_o), .cpu_mod_fcw_o(cpu_mod_fcw_o),
    .cpu_mod_shift_o(cpu_mod_shift_o), .cpu_note_en_o(cpu_note_en_o),
    .cpu_req_o(cpu_req_o), .cpu_ack_i(cpu_ack_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NV; i++) m_car[i] = 24'd0;
    m_mod = 24'd0; m_shift = 5'd0; m_note = '0;
  endtask

  task automatic snap();
    for (int i = 0; i < NV; i++) e_car[24*i +: 24] = m_car[i];
    e_mod = m_mod; e_shift = m_shift; e_note = m_note;
  endtask

  function automatic logic [31:0] m_rd(input logic [3:0] a);
    if (a < 4'(NV)) return {8'd0, m_car[a[1:0]]};
    case (a)
      4'd8:    return {8'd0, m_mod};
      4'd9:    return {27'd0, m_shift};
      4'd10:   return {28'd0, m_note};
      default: return 32'd0;
    endcase
  endfunction

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    wr_en_i = 1'b1; wr_addr_i = a; wr_data_i = d;
    tick();
    wr_en_i = 1'b0;
    if (a < 4'(NV)) m_car[a[1:0]] = d[23:0];
    else if (a == 4'd8) m_mod = d[23:0];
    else if (a == 4'd9) m_shift = d[4:0];
    else if (a == 4'd10) m_note = d[NV-1:0];
  endtask

  task automatic rd_chk(input string tag, input logic [3:0] a, input logic [31:0] exp);
    rd_addr_i = a; #1;
    chk(tag, rd_data_o, exp);
    rd_addr_i = 4'd12; #1;
  endtask

  task automatic stat(input string tag, input logic [2:0] exp);
    rd_chk(tag, 4'd12, {29'd0, exp});
  endtask

  task automatic chk_out(input string tag);
    chk({tag, ".car"},   cpu_carrier_fcws_o, e_car);
    chk({tag, ".mod"},   cpu_mod_fcw_o,      e_mod);
    chk({tag, ".shift"}, cpu_mod_shift_o,    e_shift);
    chk({tag, ".note"},  cpu_note_en_o,      e_note);
  endtask

  task automatic wait_req(input string tag, input logic lvl);
    int n = 0;
    while (cpu_req_o !== lvl && n < 50) begin tick(); n++; end
    chk(tag, cpu_req_o, lvl);
  endtask

  task automatic wait_busy(input string tag, input logic lvl);
    int n = 0;
    rd_addr_i = 4'd12; #1;
    while (rd_data_o[0] !== lvl && n < 50) begin tick(); n++; end
    chk(tag, rd_data_o[0], lvl);
  endtask

  // Commit, then check exact latency of data and request.
  task automatic commit_chk(input string tag);
    snap();
    wr(4'd11, $urandom);
    chk_out({tag, ".load"});
    chk({tag, ".req_lo"}, cpu_req_o, 1'b0);
    tick();
    chk({tag, ".req_hi"}, cpu_req_o, 1'b1);
  endtask

  // Acknowledge responder with a fixed delay; outputs must stay frozen throughout.
  task automatic ack_cycle(input string tag, input int dly);
    repeat (dly) tick();
    chk_out({tag, ".frozen"});
    cpu_ack_i = 1'b1;
    wait_req({tag, ".req_fall"}, 1'b0);
    repeat (dly) tick();
    cpu_ack_i = 1'b0;
    wait_busy({tag, ".idle"}, 1'b0);
    chk_out({tag, ".held"});
  endtask

  initial begin
    int dly;
    logic [3:0] a;
    rst_i = 1'b1; wr_en_i = 1'b0; wr_addr_i = 4'd0; wr_data_i = 32'd0;
    rd_addr_i = 4'd12; cpu_ack_i = 1'b0;
    model_reset(); snap();
    repeat (3) tick();
    rst_i = 1'b0;
    tick();

    // Reset state
    chk_out("reset");
    chk("reset.req", cpu_req_o, 1'b0);
    for (int i = 0; i < 16; i++) rd_chk("reset.rd", 4'(i), 32'd0);

    // Directed basic transfer
    wr(4'd0, 32'h00123456); wr(4'd8, 32'h0000ABCD); wr(4'd9, 32'd3); wr(4'd10, 32'h5);
    chk_out("t1.pre");
    commit_chk("t1");
    stat("t1.busy", 3'b001);
    ack_cycle("t1", 3);
    stat("t1.done", 3'b000);

    // Coalescing of commits issued during REQ
    commit_chk("t2");
    wr(4'd1, 32'h00111111);
    wr(4'd11, 32'd0);
    stat("t2.pend", 3'b011);
    wr(4'd11, 32'd0);
    stat("t2.pend2", 3'b011);
    chk_out("t2.frozen1");
    cpu_ack_i = 1'b1;
    wait_req("t2.req_fall", 1'b0);
    stat("t2.wl", 3'b011);
    cpu_ack_i = 1'b0;
    wait_busy("t2.idle", 1'b0);
    stat("t2.idle_pend", 3'b010);
    snap();
    tick();
    chk_out("t2.load2");
    chk("t2.car1", cpu_carrier_fcws_o[47:24], 24'h111111);
    stat("t2.pend_clr", 3'b001);
    wait_req("t2.req2", 1'b1);
    ack_cycle("t2b", 2);
    repeat (6) begin
      tick();
      chk("t2.no_extra", {cpu_req_o, rd_data_o[2:0]}, 4'b0000);
    end

    // Shadow write during REQ must not disturb outputs
    wr(4'd0, $urandom); wr(4'd2, $urandom);
    commit_chk("t3");
    wr(4'd0, 32'h00FFFFFF);
    chk_out("t3.frozen");
    rd_chk("t3.rd0", 4'd0, 32'h00FFFFFF);
    ack_cycle("t3", 1);
    commit_chk("t3b");
    chk("t3b.car0", cpu_carrier_fcws_o[23:0], 24'hFFFFFF);
    ack_cycle("t3b", 2);

    // Randomized writes, reads and transfers against the model
    for (int r = 0; r < 8; r++) begin
      for (int k = 0; k < 6; k++) begin
        a = 4'($urandom_range(0, 15));
        if (a == 4'd11) a = 4'd13;
        wr(a, $urandom);
      end
      chk_out("rnd.undisturbed");
      for (int k = 0; k < 4; k++) begin
        a = 4'($urandom_range(0, 15));
        if (a == 4'd12) a = 4'd11;
        rd_chk("rnd.rd", a, m_rd(a));
      end
      commit_chk("rnd");
      dly = $urandom_range(1, 4);
      ack_cycle("rnd", dly);
      stat("rnd.done", 3'b000);
    end

    // Reset mid-REQ with ack held high, then stale-ack blocking
    wr(4'd3, $urandom);
    commit_chk("t4");
    cpu_ack_i = 1'b1; rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    model_reset(); snap();
    chk("t4.req_drop", cpu_req_o, 1'b0);
    stat("t4.status", 3'b000);
    chk_out("t4.outs");
    repeat (3) tick();
    wr(4'd0, $urandom); wr(4'd10, $urandom);
    snap();
    wr(4'd11, 32'd0);
    for (int k = 0; k < 5; k++) begin
      stat("t4.blocked", 3'b010);
      chk("t4.no_req", cpu_req_o, 1'b0);
      tick();
    end
    cpu_ack_i = 1'b0;
    wait_busy("t4.start", 1'b1);
    chk_out("t4.load");
    stat("t4.loadstat", 3'b001);
    wait_req("t4.req", 1'b1);
    ack_cycle("t4", 3);
    stat("t4.done", 3'b000);

`ifdef SYNTH_CFG_TIMEOUT_EN
    // Timeout abort with sticky err
    begin
      int n = 0;
      commit_chk("t5");
      while (cpu_req_o === 1'b1 && n < 100) begin tick(); n++; end
      chk("t5.req_cycles", n, 16);
      stat("t5.wl", 3'b101);
      tick();
      stat("t5.err", 3'b100);
      wr(4'd12, 32'h3);
      stat("t5.sticky", 3'b100);
      wr(4'd12, 32'h4);
      stat("t5.clr", 3'b000);
    end
`else
    // Without timeout, REQ waits indefinitely
    commit_chk("t5");
    repeat (40) tick();
    chk("t5.still_req", cpu_req_o, 1'b1);
    stat("t5.noerr", 3'b001);
    ack_cycle("t5", 1);
    stat("t5.done", 3'b000);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
